// File: rtl/scoreboarded_register_file.sv
// scoreboarded_register_file
//   Multi-ported register file with a per-register busy (scoreboard) bit.
//   - Combinational reads on NUM_READ_PORTS ports, each reporting whether
//     its addressed register has a pending producer (busy).
//   - One general write port and one stack write port.
//     The stack write port only targets register 0 and wins over the general port.
//   - A reserve port marks a register busy. A write to a register clears its
//     busy bit, unless the same register is reserved in the same cycle.
//   - busy_count is a registered population count of the busy bits.
//   Optional feature: define RF_WRITE_BYPASS_EN to forward same-cycle write
//   data, and the write's busy clear, to the read ports.
module scoreboarded_register_file #(
  parameter int ADDR_WIDTH_RF  = 3,
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_READ_PORTS = 2
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_READ_PORTS*ADDR_WIDTH_RF-1:0] read_address,
  output logic [NUM_READ_PORTS*DATA_WIDTH-1:0]    read_data,
  output logic [NUM_READ_PORTS-1:0]               read_ready,
  input  logic                                 general_register_write_enable,
  input  logic [ADDR_WIDTH_RF-1:0]             general_register_write_address,
  input  logic [DATA_WIDTH-1:0]                general_register_write_data,
  input  logic                                 stack_write_enable,
  input  logic [DATA_WIDTH-1:0]                stack_register_write_data,
  input  logic                                 reserve_enable,
  input  logic [ADDR_WIDTH_RF-1:0]             reserve_address,
  output logic [ADDR_WIDTH_RF:0]               busy_count
);

  localparam int NUM_REGS = 1 << ADDR_WIDTH_RF;
  localparam int CNT_W    = ADDR_WIDTH_RF + 1;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
  logic [NUM_REGS-1:0]   busy_q;
  logic [NUM_REGS-1:0]   busy_d;
  logic [CNT_W-1:0]      busy_count_q;
  logic [CNT_W-1:0]      busy_count_d;
  logic [ADDR_WIDTH_RF-1:0] rd_addr;

  // Next register/busy state.
  // Ordering: the general write first, then the stack write overrides
  // register 0, then a reserve re-sets busy. The reserve re-set means a new
  // producer wins over a write's clear.
  always_comb begin
    // NOTE: combinational blocks use blocking '=' and assign every output a
    // default first, so later statements override earlier ones and no latch
    // is inferred.
    regs_d = regs_q;
    busy_d = busy_q;
    if (general_register_write_enable) begin
      regs_d[general_register_write_address] = general_register_write_data;
      busy_d[general_register_write_address] = 1'b0;
    end
    if (stack_write_enable) begin
      regs_d[0] = stack_register_write_data;
      busy_d[0] = 1'b0;
    end
    if (reserve_enable) begin
      busy_d[reserve_address] = 1'b1;
    end
    busy_count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      busy_count_d = busy_count_d + {{(CNT_W-1){1'b0}}, busy_d[i]};
    end
  end

  // State registers. Synchronous reset has priority over any write or reserve.
  always_ff @(posedge clk) begin
    // NOTE: sequential blocks use non-blocking '<=' so every flop samples its
    // pre-edge inputs. The register array is reset here as well, because
    // reads must return 0 immediately after reset.
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
      busy_q       <= '0;
      busy_count_q <= '0;
    end else begin
      regs_q       <= regs_d;
      busy_q       <= busy_d;
      busy_count_q <= busy_count_d;
    end
  end

  assign busy_count = busy_count_q;

  // Read ports.
  // Data and readiness come from registered state, with optional same-cycle
  // write forwarding.
  always_comb begin
    read_data  = '0;
    read_ready = '0;
    rd_addr    = '0;
    for (int p = 0; p < NUM_READ_PORTS; p++) begin
      rd_addr = read_address[p*ADDR_WIDTH_RF +: ADDR_WIDTH_RF];
      read_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[rd_addr];
      read_ready[p] = ~busy_q[rd_addr];
`ifdef RF_WRITE_BYPASS_EN
      // A matching write is treated as having already cleared busy.
      // A reserve in the same cycle is not visible until the next edge.
      if (general_register_write_enable &&
          (rd_addr == general_register_write_address)) begin
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = general_register_write_data;
        read_ready[p] = 1'b1;
      end
      if (stack_write_enable && (rd_addr == '0)) begin
        read_data[p*DATA_WIDTH +: DATA_WIDTH] = stack_register_write_data;
        read_ready[p] = 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_scoreboarded_register_file.sv
// Directed self-checking bench for scoreboarded_register_file (default
// parameters). Expectations follow RF_WRITE_BYPASS_EN when it is defined.
module tb_scoreboarded_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  read_address;
  logic [31:0] read_data;
  logic [1:0]  read_ready;
  logic        general_register_write_enable;
  logic [2:0]  general_register_write_address;
  logic [15:0] general_register_write_data;
  logic        stack_write_enable;
  logic [15:0] stack_register_write_data;
  logic        reserve_enable;
  logic [2:0]  reserve_address;
  logic [3:0]  busy_count;

  int total_checks  = 0;
  int passed_checks = 0;
  int failed_checks = 0;

  always #5 clk = ~clk;

  scoreboarded_register_file dut (
    .clk                            (clk),
    .reset                          (reset),
    .read_address                   (read_address),
    .read_data                      (read_data),
    .read_ready                     (read_ready),
    .general_register_write_enable  (general_register_write_enable),
    .general_register_write_address (general_register_write_address),
    .general_register_write_data    (general_register_write_data),
    .stack_write_enable             (stack_write_enable),
    .stack_register_write_data      (stack_register_write_data),
    .reserve_enable                 (reserve_enable),
    .reserve_address                (reserve_address),
    .busy_count                     (busy_count)
  );

  task automatic check(input string tag, input logic [31:0] observed,
                       input logic [31:0] expected);
    total_checks++;
    assert (observed === expected) begin
      passed_checks++;
    end else begin
      failed_checks++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge; inputs change and outputs are sampled 1 ns later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    general_register_write_enable  = 1'b0;
    general_register_write_address = '0;
    general_register_write_data    = '0;
    stack_write_enable             = 1'b0;
    stack_register_write_data      = '0;
    reserve_enable                 = 1'b0;
    reserve_address                = '0;
  endtask

  // Read one address on both ports. Expect zero data and both ports ready.
  task automatic check_all_clear(input string tag);
    for (int a = 0; a < 8; a++) begin
      read_address = {a[2:0], a[2:0]};
      #1;
      check($sformatf("%s_data_a%0d", tag, a), read_data, 32'h0);
      check($sformatf("%s_ready_a%0d", tag, a), {30'd0, read_ready}, 32'd3);
    end
    check({tag, "_count"}, {28'd0, busy_count}, 32'd0);
  endtask

  initial begin
    reset = 1'b1;
    read_address = '0;
    idle_inputs();
    step();
    step();
    reset = 1'b0;

    // After reset: every register reads zero and is ready.
    check_all_clear("reset");

    // Write 0x1234 to address 5 while port 1 reads address 5.
    general_register_write_enable  = 1'b1;
    general_register_write_address = 3'd5;
    general_register_write_data    = 16'h1234;
    read_address = {3'd5, 3'd0};
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("wr5_same_cycle_data", {16'd0, read_data[31:16]}, 32'h1234);
`else
    check("wr5_same_cycle_data", {16'd0, read_data[31:16]}, 32'h0000);
`endif
    check("wr5_same_cycle_ready", {31'd0, read_ready[1]}, 32'd1);
    step();
    idle_inputs();
    #1;
    check("wr5_next_cycle_data", {16'd0, read_data[31:16]}, 32'h1234);
    check("wr5_port0_addr0", {16'd0, read_data[15:0]}, 32'h0000);

    // Stack write and general write to register 0 in the same cycle: stack wins.
    general_register_write_enable  = 1'b1;
    general_register_write_address = 3'd0;
    general_register_write_data    = 16'hAAAA;
    stack_write_enable             = 1'b1;
    stack_register_write_data      = 16'h5555;
    step();
    idle_inputs();
    read_address = {3'd5, 3'd0};
    #1;
    check("stack_wins_r0", {16'd0, read_data[15:0]}, 32'h5555);
    check("stack_r5_kept", {16'd0, read_data[31:16]}, 32'h1234);

    // Reserve register 3, then clear it by writing 0x0077.
    reserve_enable  = 1'b1;
    reserve_address = 3'd3;
    step();
    idle_inputs();
    read_address = {3'd5, 3'd3};
    #1;
    check("rsv3_ready", {30'd0, read_ready}, 32'd2);
    check("rsv3_count", {28'd0, busy_count}, 32'd1);
    general_register_write_enable  = 1'b1;
    general_register_write_address = 3'd3;
    general_register_write_data    = 16'h0077;
    #1;
`ifdef RF_WRITE_BYPASS_EN
    check("wr3_same_cycle_ready", {31'd0, read_ready[0]}, 32'd1);
`else
    check("wr3_same_cycle_ready", {31'd0, read_ready[0]}, 32'd0);
`endif
    step();
    idle_inputs();
    #1;
    check("wr3_ready", {30'd0, read_ready}, 32'd3);
    check("wr3_count", {28'd0, busy_count}, 32'd0);
    check("wr3_data", {16'd0, read_data[15:0]}, 32'h0077);

    // Reserve and write register 2 in the same cycle: data stored, busy kept.
    reserve_enable                 = 1'b1;
    reserve_address                = 3'd2;
    general_register_write_enable  = 1'b1;
    general_register_write_address = 3'd2;
    general_register_write_data    = 16'h0222;
    step();
    idle_inputs();
    read_address = {3'd3, 3'd2};
    #1;
    check("rsvwr2_data", {16'd0, read_data[15:0]}, 32'h0222);
    check("rsvwr2_ready", {30'd0, read_ready}, 32'd2);
    check("rsvwr2_count", {28'd0, busy_count}, 32'd1);

    // Reserving an already busy register keeps it busy; the count is unchanged.
    reserve_enable  = 1'b1;
    reserve_address = 3'd2;
    step();
    idle_inputs();
    #1;
    check("rersv2_ready", {31'd0, read_ready[0]}, 32'd0);
    check("rersv2_count", {28'd0, busy_count}, 32'd1);

    // A stack write clears the busy bit of register 0.
    reserve_enable  = 1'b1;
    reserve_address = 3'd0;
    step();
    idle_inputs();
    read_address = {3'd2, 3'd0};
    #1;
    check("rsv0_count", {28'd0, busy_count}, 32'd2);
    check("rsv0_ready", {30'd0, read_ready}, 32'd0);
    stack_write_enable        = 1'b1;
    stack_register_write_data = 16'h0999;
    step();
    idle_inputs();
    #1;
    check("stk0_count", {28'd0, busy_count}, 32'd1);
    check("stk0_ready", {30'd0, read_ready}, 32'd1);
    check("stk0_data", {16'd0, read_data[15:0]}, 32'h0999);

    // Reserve every register: busy_count reaches its maximum of 8.
    for (int a = 0; a < 8; a++) begin
      reserve_enable  = 1'b1;
      reserve_address = a[2:0];
      step();
    end
    idle_inputs();
    read_address = {3'd7, 3'd4};
    #1;
    check("rsv_all_count", {28'd0, busy_count}, 32'd8);
    check("rsv_all_ready", {30'd0, read_ready}, 32'd0);

    // Reset with a concurrent write and reserve: reset wins, everything clears.
    reset                          = 1'b1;
    general_register_write_enable  = 1'b1;
    general_register_write_address = 3'd4;
    general_register_write_data    = 16'hBEEF;
    reserve_enable                 = 1'b1;
    reserve_address                = 3'd4;
    step();
    reset = 1'b0;
    idle_inputs();
    check_all_clear("reset2");

    $display("%0d/%0d checks passed", passed_checks, total_checks);
    $finish;
  end

endmodule

// File: doc/scoreboarded_register_file.md
SCOREBOARDED_REGISTER_FILE -- requirements
Module: scoreboarded_register_file

Interface
REQ-001 SHALL have parameter ADDR_WIDTH_RF, default 3; register address width, 2**ADDR_WIDTH_RF registers.
REQ-002 SHALL have parameter DATA_WIDTH, default 16; register data width.
REQ-003 SHALL have parameter NUM_READ_PORTS, default 2, legal range 1..4; number of independent read ports.
REQ-004 SHALL have port clk  input  1  single system clock, all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port read_address  input  NUM_READ_PORTS*ADDR_WIDTH_RF  packed read addresses, port p at bits [p*ADDR_WIDTH_RF +: ADDR_WIDTH_RF].
REQ-007 SHALL have port read_data  output  NUM_READ_PORTS*DATA_WIDTH  packed read data, same packing as read_address.
REQ-008 SHALL have port read_ready  output  NUM_READ_PORTS  per-port 1 when the addressed register is not busy.
REQ-009 SHALL have port general_register_write_enable  input  1  general write strobe.
REQ-010 SHALL have port general_register_write_address  input  ADDR_WIDTH_RF  general write target.
REQ-011 SHALL have port general_register_write_data  input  DATA_WIDTH  general write data.
REQ-012 SHALL have port stack_write_enable  input  1  strobe writing register 0 only.
REQ-013 SHALL have port stack_register_write_data  input  DATA_WIDTH  stack write data.
REQ-014 SHALL have port reserve_enable  input  1  marks a register busy (pending producer).
REQ-015 SHALL have port reserve_address  input  ADDR_WIDTH_RF  register to reserve.
REQ-016 SHALL have port busy_count  output  ADDR_WIDTH_RF+1  number of currently busy registers.

Function
REQ-017 Reads SHALL be combinational from register state: read_data port p = registers[read_address p], zero-cycle latency.
REQ-018 General write SHALL update registers[general_register_write_address] at the rising edge when its enable is 1.
REQ-019 Stack write SHALL update registers[0] at the rising edge when stack_write_enable is 1.
REQ-020 Simultaneous general write to address 0 and stack write SHALL store stack_register_write_data; general write data discarded.
REQ-021 Each register SHALL have one busy bit; reserve_enable SHALL set busy[reserve_address] at the next edge.
REQ-022 A general write SHALL clear busy of its target at the edge; a stack write SHALL clear busy[0].
REQ-023 Reserve and clearing write to the same address in one cycle SHALL leave busy set (new producer wins); data still written.
REQ-024 Reserving an already busy register SHALL keep it busy with no error indication.
REQ-025 Write to a non-busy register SHALL be accepted normally; busy stays 0.
REQ-026 read_ready p SHALL equal NOT busy[read_address p], using registered busy state (no same-cycle update).
REQ-027 busy_count SHALL be a registered count equal to the population of busy bits, updated in the same edge as the bits; range 0..2**ADDR_WIDTH_RF without wrap.

Reset
REQ-028 When reset is 1 at a rising edge, all registers SHALL become 0, all busy bits 0, busy_count 0.
REQ-029 Reset SHALL take priority over any simultaneous write or reserve in that cycle; those operations are lost.
REQ-030 After reset, read_data SHALL be 0 on all ports and read_ready SHALL be all ones.

Configuration
REQ-031 Macro RF_WRITE_BYPASS_EN SHALL, when defined, forward same-cycle write data to read ports: read address matching general write target returns general_register_write_data; address 0 with stack write returns stack_register_write_data (stack wins per REQ-020); matching read_ready reports 1 unless also reserved that cycle is ignored (registered busy with clear applied).
REQ-032 Without RF_WRITE_BYPASS_EN, reads SHALL return only stored values and read_ready SHALL follow REQ-026 exactly.

Verification
REQ-033 Reset, then read all addresses on all ports -> read_data 0, read_ready all 1, busy_count 0.
REQ-034 Write 0x1234 to address 5, next cycle read address 5 on port 1 -> 0x1234; in write cycle without bypass -> old value 0, with bypass -> 0x1234.
REQ-035 General write 0xAAAA and stack write 0x5555 both to register 0 same cycle -> register 0 reads 0x5555.
REQ-036 Reserve address 3, next cycle read 3 -> read_ready 0, busy_count 1; write 0x0077 to 3 -> next cycle read_ready 1, busy_count 0, data 0x0077.
REQ-037 Reserve and write address 2 same cycle -> data stored, busy[2] 1, busy_count 1.
REQ-038 Reserve all 8 registers then assert reset with concurrent write to address 4 -> all data 0, busy_count 0, read_ready all 1.
